// File: rtl/uart_stream_pkg.sv
// Shared types and helpers for the uart_stream UART endpoint.
// Define UART_STREAM_PARITY_EN for an even-parity (8E1, 11-bit) frame; default is 8N1.
package uart_stream_pkg;

`ifdef UART_STREAM_PARITY_EN
  localparam int FrameBits = 11;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;
`else
  localparam int FrameBits = 10;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
`endif

  function automatic int cycles_per_symbol(input int freq, input int baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/uart_stream_fifo.sv
// Byte-wide synchronous FIFO; extra pointer MSB distinguishes full from empty.
module uart_stream_fifo #(
  parameter int Depth = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  logic [7:0] data_i,
  input  logic       pop_i,
  output logic [7:0] data_o,
  output logic       full_o,
  output logic       empty_o
);
  localparam int AW = $clog2(Depth);

  if (Depth < 2 || (Depth & (Depth - 1)) != 0) begin : g_chk_depth
    $error("uart_stream_fifo: Depth must be a power of two >= 2");
  end

  logic [7:0]  mem [Depth];
  logic [AW:0] wptr_q, rptr_q;
  logic        do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign data_o  = mem[rptr_q[AW-1:0]];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wptr_q[AW-1:0]] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_stream_core.sv
// UART endpoint: valid/ready byte stream <-> serial line, FIFO-buffered TX, single-entry RX.
// Frame format selected by UART_STREAM_PARITY_EN (8E1 when defined, 8N1 otherwise).
module uart_stream_core
  import uart_stream_pkg::*;
#(
  parameter int FREQ        = 50000000,
  parameter int BAUD        = 115200,
  parameter int TxFifoDepth = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       rx_overrun_o,
  output logic       rx_frame_err_o,
  output logic       tx_o,
  input  logic       rx_i
);
  localparam int C  = cycles_per_symbol(FREQ, BAUD);
  localparam int CW = $clog2(C);

  if (C < 4) begin : g_chk_c
    $error("uart_stream_core: FREQ/BAUD must be at least 4");
  end

  // ---------------- TX path ----------------
  logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]      fifo_data;
  tx_state_e       tx_state_q, tx_state_d;
  logic [CW-1:0]   tx_cnt_q;
  logic [2:0]      tx_bit_q;
  logic [7:0]      tx_shreg_q;
  logic            tx_q, tx_line_d, tx_bit_end;

  assign tx_ready_o = !fifo_full;
  assign fifo_push  = tx_valid_i && tx_ready_o;
  assign tx_bit_end = (tx_cnt_q == CW'(C - 1));
  assign tx_o       = tx_q;

  uart_stream_fifo #(.Depth(TxFifoDepth)) u_tx_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .data_i  (tx_data_i),
    .pop_i   (fifo_pop),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    tx_state_d = tx_state_q;
    fifo_pop   = 1'b0;
    case (tx_state_q)
      TX_IDLE: if (!fifo_empty) begin
        fifo_pop   = 1'b1;
        tx_state_d = TX_START;
      end
      TX_START: if (tx_bit_end) tx_state_d = TX_DATA;
      TX_DATA: if (tx_bit_end && tx_bit_q == 3'd7) begin
`ifdef UART_STREAM_PARITY_EN
        tx_state_d = TX_PARITY;
`else
        tx_state_d = TX_STOP;
`endif
      end
`ifdef UART_STREAM_PARITY_EN
      TX_PARITY: if (tx_bit_end) tx_state_d = TX_STOP;
`endif
      // Chain straight into the next start bit so queued frames stay contiguous.
      TX_STOP: if (tx_bit_end) begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          tx_state_d = TX_START;
        end else begin
          tx_state_d = TX_IDLE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    tx_line_d = 1'b1;
    case (tx_state_q)
      TX_START:  tx_line_d = 1'b0;
      TX_DATA:   tx_line_d = tx_shreg_q[tx_bit_q];
`ifdef UART_STREAM_PARITY_EN
      TX_PARITY: tx_line_d = ^tx_shreg_q;
`endif
      default:   tx_line_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shreg_q <= '0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_q       <= tx_line_d;
      if (fifo_pop) tx_shreg_q <= fifo_data;
      if (tx_state_q == TX_IDLE || tx_bit_end) tx_cnt_q <= '0;
      else                                      tx_cnt_q <= tx_cnt_q + 1'b1;
      if (tx_state_q == TX_IDLE)                tx_bit_q <= '0;
      else if (tx_state_q == TX_DATA && tx_bit_end) tx_bit_q <= tx_bit_q + 1'b1;
    end
  end

  // ---------------- RX path ----------------
  logic            rx_s1_q, rx_s2_q, rx_s3_q;
  rx_state_e       rx_state_q, rx_state_d;
  logic [CW-1:0]   rx_cnt_q;
  logic [2:0]      rx_bit_q;
  logic [7:0]      rx_shreg_q, rx_data_q;
  logic            rx_valid_q, rx_ovr_q, rx_ferr_q;
  logic            rx_fall, rx_half, rx_full, rx_stop_smp, rx_par_err;

  assign rx_fall        = rx_s3_q && !rx_s2_q;
  assign rx_half        = (rx_cnt_q == CW'(C / 2 - 1));
  assign rx_full        = (rx_cnt_q == CW'(C - 1));
  assign rx_stop_smp    = (rx_state_q == RX_STOP) && rx_full;
  assign rx_data_o      = rx_data_q;
  assign rx_valid_o     = rx_valid_q;
  assign rx_overrun_o   = rx_ovr_q;
  assign rx_frame_err_o = rx_ferr_q;

  always_comb begin
    rx_state_d = rx_state_q;
    case (rx_state_q)
      RX_IDLE:  if (rx_fall) rx_state_d = RX_START;
      // Line back high at mid start bit means a glitch, not a frame.
      RX_START: if (rx_half) rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_full && rx_bit_q == 3'd7) begin
`ifdef UART_STREAM_PARITY_EN
        rx_state_d = RX_PARITY;
`else
        rx_state_d = RX_STOP;
`endif
      end
`ifdef UART_STREAM_PARITY_EN
      RX_PARITY: if (rx_full) rx_state_d = RX_STOP;
`endif
      RX_STOP:  if (rx_full) rx_state_d = RX_IDLE;
      default:  rx_state_d = RX_IDLE;
    endcase
  end

`ifdef UART_STREAM_PARITY_EN
  always_ff @(posedge clk_i) begin
    if (rst_i)                                      rx_par_err <= 1'b0;
    else if (rx_state_q == RX_PARITY && rx_full)    rx_par_err <= rx_s2_q ^ (^rx_shreg_q);
  end
`else
  assign rx_par_err = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_s3_q    <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shreg_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_ovr_q   <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_s1_q    <= rx_i;
      rx_s2_q    <= rx_s1_q;
      rx_s3_q    <= rx_s2_q;
      rx_state_q <= rx_state_d;
      if (rx_state_q == RX_IDLE || rx_state_d != rx_state_q || rx_full) rx_cnt_q <= '0;
      else                                                                rx_cnt_q <= rx_cnt_q + 1'b1;
      if (rx_state_q == RX_IDLE) begin
        rx_bit_q <= '0;
      end else if (rx_state_q == RX_DATA && rx_full) begin
        rx_shreg_q <= {rx_s2_q, rx_shreg_q[7:1]};
        rx_bit_q   <= rx_bit_q + 1'b1;
      end
      rx_ovr_q  <= 1'b0;
      rx_ferr_q <= 1'b0;
      if (rx_valid_q && rx_ready_i) rx_valid_q <= 1'b0;
      // A handshake in the same cycle as the stop sample frees the register for the new byte.
      if (rx_stop_smp) begin
        if (!rx_s2_q || rx_par_err) begin
          rx_ferr_q <= 1'b1;
        end else if (!rx_valid_q || rx_ready_i) begin
          rx_data_q  <= rx_shreg_q;
          rx_valid_q <= 1'b1;
        end else begin
          rx_ovr_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_stream_core.sv
// Self-checking bench for uart_stream_core at C = 10 cycles per bit.
module tb_uart_stream_core;
  localparam int FREQ = 1000000;
  localparam int BAUD = 100000;
  localparam int C    = 10;
`ifdef UART_STREAM_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [7:0] tx_data_i = 8'h00;
  logic       tx_valid_i = 1'b0;
  logic       tx_ready_o;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_ready_i = 1'b0;
  logic       rx_overrun_o, rx_frame_err_o;
  logic       tx_o;
  logic       rx_i = 1'b1;

  uart_stream_core #(.FREQ(FREQ), .BAUD(BAUD), .TxFifoDepth(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
    .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
    .rx_overrun_o(rx_overrun_o), .rx_frame_err_o(rx_frame_err_o),
    .tx_o(tx_o), .rx_i(rx_i)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [NBITS-1:0] mk_frame(input logic [7:0] d, input logic stopb);
`ifdef UART_STREAM_PARITY_EN
    return {stopb, ^d, d, 1'b0};
`else
    return {stopb, d, 1'b0};
`endif
  endfunction

  // TX scoreboard: expected bytes queued at push, checked when a frame is decoded off tx_o.
  logic [7:0]       txq[$];
  int               tx_starts[$];
  bit               tx_ignore = 1'b0;
  logic             mon_prev = 1'b1;
  logic [NBITS-1:0] mon_fr;
  logic [7:0]       mon_exp;
  bit               mon_ign;

  initial begin
    forever begin
      @(negedge clk_i);
      if (mon_prev === 1'b1 && tx_o === 1'b0) begin
        mon_ign = tx_ignore;
        tx_starts.push_back(cyc);
        for (int i = 0; i < NBITS; i++) begin
          repeat ((i == 0) ? 5 : 10) @(negedge clk_i);
          mon_fr[i] = tx_o;
        end
        repeat (4) @(negedge clk_i);
        mon_prev = tx_o;
        if (!mon_ign) begin
          if (txq.size() == 0) begin
            checks++; errors++;
            $display("FAIL tx_unexpected_frame: got frame 0x%0h expected none", mon_fr);
          end else begin
            mon_exp = txq.pop_front();
            chk("tx_frame", 32'(mon_fr), 32'(mk_frame(mon_exp, 1'b1)));
          end
        end
      end else begin
        mon_prev = tx_o;
      end
    end
  end

  // RX scoreboard: expected bytes queued when a frame is driven, checked on handshake.
  logic [7:0] rxq[$];
  int ovr_cnt = 0, ferr_cnt = 0, vld_cyc = 0;

  initial begin
    forever begin
      @(negedge clk_i);
      if (!rst_i) begin
        if (rx_overrun_o === 1'b1)   ovr_cnt++;
        if (rx_frame_err_o === 1'b1) ferr_cnt++;
        if (rx_valid_o === 1'b1)     vld_cyc++;
        if (rx_valid_o === 1'b1 && rx_ready_i === 1'b1) begin
          if (rxq.size() == 0) begin
            checks++; errors++;
            $display("FAIL rx_unexpected_byte: got 0x%0h expected none", rx_data_o);
          end else begin
            chk("rx_data", 32'(rx_data_o), 32'(rxq.pop_front()));
          end
        end
      end
    end
  end

  task automatic send_rx(input logic [7:0] d, input logic stopb, input int hold_low);
    logic [NBITS-1:0] fr;
    fr = mk_frame(d, stopb);
    for (int i = 0; i < NBITS; i++) begin
      rx_i = fr[i];
      repeat (C) @(negedge clk_i);
    end
    if (hold_low > 0) begin
      rx_i = 1'b0;
      repeat (hold_low) @(negedge clk_i);
    end
    rx_i = 1'b1;
  endtask

  task automatic wait_tx_drain(input int budget);
    int t;
    t = 0;
    while (txq.size() != 0 && t < budget) begin
      @(negedge clk_i);
      t++;
    end
    chk("tx_drain", 32'(txq.size()), 32'd0);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stopb;
    int         hold_low;
    int         exp_vld;
    int         exp_ferr;
  } rxvec_t;

  rxvec_t vec[5];
  int v0, f0, o0, n0, t, stall, lows;

  initial begin
    vec[0] = '{data: 8'h3C, stopb: 1'b1, hold_low: 0,  exp_vld: 1, exp_ferr: 0};
    vec[1] = '{data: 8'h00, stopb: 1'b1, hold_low: 0,  exp_vld: 1, exp_ferr: 0};
    vec[2] = '{data: 8'hFF, stopb: 1'b1, hold_low: 0,  exp_vld: 1, exp_ferr: 0};
    vec[3] = '{data: 8'h55, stopb: 1'b0, hold_low: 0,  exp_vld: 0, exp_ferr: 1};
    vec[4] = '{data: 8'h00, stopb: 1'b0, hold_low: 60, exp_vld: 0, exp_ferr: 1};

    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_tx_o", 32'(tx_o), 32'd1);
    chk("rst_tx_ready", 32'(tx_ready_o), 32'd1);
    chk("rst_rx_valid", 32'(rx_valid_o), 32'd0);
    chk("rst_rx_data", 32'(rx_data_o), 32'd0);
    chk("rst_overrun", 32'(rx_overrun_o), 32'd0);
    chk("rst_frame_err", 32'(rx_frame_err_o), 32'd0);

    // Single TX byte: start bit appears two cycles after the accepting edge.
    tx_data_i = 8'hA5; tx_valid_i = 1'b1;
    chk("tx_ready_idle", 32'(tx_ready_o), 32'd1);
    txq.push_back(8'hA5);
    @(posedge clk_i); #1 tx_valid_i = 1'b0;
    @(negedge clk_i); chk("tx_lat_c1", 32'(tx_o), 32'd1);
    @(negedge clk_i); chk("tx_lat_c2", 32'(tx_o), 32'd1);
    @(negedge clk_i); chk("tx_lat_start", 32'(tx_o), 32'd0);
    wait_tx_drain(300);
    repeat (10) @(negedge clk_i);
    chk("tx_idle_high", 32'(tx_o), 32'd1);

    // Five bytes back-to-back: FIFO fills, frames are contiguous.
    n0 = tx_starts.size();
    stall = 0;
    tx_valid_i = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tx_data_i = 8'(i);
      t = 0;
      while (tx_ready_o !== 1'b1 && t < 2000) begin
        @(negedge clk_i);
        t++;
      end
      stall += t;
      txq.push_back(8'(i));
      @(negedge clk_i);
    end
    tx_valid_i = 1'b0;
    chk("tx_no_stall", 32'(stall), 32'd0);
    chk("tx_full_ready", 32'(tx_ready_o), 32'd0);
    wait_tx_drain(800);
    chk("tx_frame_count", 32'(tx_starts.size() - n0), 32'd5);
    if (tx_starts.size() - n0 == 5)
      chk("tx_contiguous", 32'(tx_starts[n0 + 4] - tx_starts[n0]), 32'(4 * NBITS * C));

    // RX table.
    rx_ready_i = 1'b1;
    repeat (20) @(negedge clk_i);
    foreach (vec[k]) begin
      v0 = vld_cyc; f0 = ferr_cnt; o0 = ovr_cnt;
      if (vec[k].exp_vld != 0) rxq.push_back(vec[k].data);
      send_rx(vec[k].data, vec[k].stopb, vec[k].hold_low);
      repeat (20) @(negedge clk_i);
      chk($sformatf("rx_vec%0d_valid_cycles", k), 32'(vld_cyc - v0), 32'(vec[k].exp_vld));
      chk($sformatf("rx_vec%0d_frame_err", k), 32'(ferr_cnt - f0), 32'(vec[k].exp_ferr));
      chk($sformatf("rx_vec%0d_overrun", k), 32'(ovr_cnt - o0), 32'd0);
    end

    // Short low glitch: no byte, no error.
    v0 = vld_cyc; f0 = ferr_cnt;
    rx_i = 1'b0;
    repeat (3) @(negedge clk_i);
    rx_i = 1'b1;
    repeat (150) @(negedge clk_i);
    chk("rx_glitch_valid", 32'(vld_cyc - v0), 32'd0);
    chk("rx_glitch_err", 32'(ferr_cnt - f0), 32'd0);

    // Overrun: consumer stalled across two frames.
    @(posedge clk_i); #1 rx_ready_i = 1'b0;
    @(negedge clk_i);
    o0 = ovr_cnt; f0 = ferr_cnt;
    send_rx(8'h11, 1'b1, 0);
    repeat (20) @(negedge clk_i);
    send_rx(8'h22, 1'b1, 0);
    repeat (20) @(negedge clk_i);
    chk("ovr_valid_held", 32'(rx_valid_o), 32'd1);
    chk("ovr_data_held", 32'(rx_data_o), 32'h11);
    chk("ovr_pulses", 32'(ovr_cnt - o0), 32'd1);
    chk("ovr_no_frame_err", 32'(ferr_cnt - f0), 32'd0);
    rxq.push_back(8'h11);
    @(posedge clk_i); #1 rx_ready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("ovr_drained", 32'(rx_valid_o), 32'd0);

    // Reset during data bit 4 of 0xFF with two bytes still queued.
    tx_ignore = 1'b1;
    tx_valid_i = 1'b1;
    tx_data_i = 8'hFF; @(negedge clk_i);
    tx_data_i = 8'h01; @(negedge clk_i);
    tx_data_i = 8'h02; @(negedge clk_i);
    tx_valid_i = 1'b0;
    t = 0;
    while (tx_o !== 1'b0 && t < 50) begin
      @(negedge clk_i);
      t++;
    end
    chk("rst_frame_started", 32'(tx_o), 32'd0);
    repeat (53) @(negedge clk_i);
    chk("rst_in_bit4", 32'(tx_o), 32'd1);
    rst_i = 1'b1;
    @(posedge clk_i); #1 rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_mid_tx_o", 32'(tx_o), 32'd1);
    chk("rst_mid_ready", 32'(tx_ready_o), 32'd1);
    lows = 0;
    repeat (300) begin
      @(negedge clk_i);
      if (tx_o !== 1'b1) lows++;
    end
    chk("rst_nothing_sent", 32'(lows), 32'd0);
    tx_ignore = 1'b0;

    chk("txq_empty", 32'(txq.size()), 32'd0);
    chk("rxq_empty", 32'(rxq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
